// File: rtl/way_select_controller.sv
// Way-select controller for a set-associative cache.
// Captures a lookup request, resolves the hit way or picks a tree-PLRU victim,
// updates the PLRU state of the set, and presents a registered select.
module way_select_controller #(
  parameter int unsigned lineSize = 512,
  parameter int unsigned ways     = 8,
  parameter int unsigned sets     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic [$clog2(sets)-1:0] reqSet,
  input  logic [ways-1:0]         hitVec,
  output logic [$clog2(ways)-1:0] select,
  output logic                    respValid,
  input  logic                    respReady,
  output logic                    respHit,
  output logic [$clog2(ways)-1:0] respWay,
  output logic                    errMultiHit
);

  localparam int unsigned WAY_W = $clog2(ways);
  localparam int unsigned SET_W = $clog2(sets);
  localparam int unsigned NODES = ways - 1;

  // Reject parameter sets the tree walk cannot handle.
  if (lineSize == 0 || ways < 2 || sets < 2 ||
      (ways & (ways - 1)) != 0 || (sets & (sets - 1)) != 0) begin : g_bad_params
    $error("way_select_controller: illegal parameters");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [SET_W-1:0]             set_q, set_d;
  logic [ways-1:0]              hit_q, hit_d;
  logic [WAY_W-1:0]             sel_q, sel_d;
  logic                         resp_hit_q, resp_hit_d;
  logic                         err_q, err_d;
  logic                         valid_q, valid_d;
  logic                         ready_q, ready_d;
  logic [sets-1:0][NODES-1:0]   plru_q, plru_d;

  logic [NODES-1:0]             tree_c;
  logic [NODES-1:0]             tree_upd_c;
  logic [WAY_W-1:0]             victim_c;
  logic [WAY_W-1:0]             low_c;
  logic [WAY_W-1:0]             way_c;
  logic                         any_c;
  logic                         multi_c;

  // Resolve the captured request: lowest hit way, multi-hit flag, PLRU victim,
  // and the updated tree that points away from the chosen way.
  always_comb begin
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] unode;
    logic             b;
    tree_c     = plru_q[set_q];
    any_c      = 1'b0;
    multi_c    = 1'b0;
    low_c      = '0;
    victim_c   = '0;
    node       = '0;
    unode      = '0;
    b          = 1'b0;
    for (int unsigned i = 0; i < ways; i++) begin
      if (hit_q[i]) begin
        if (any_c) begin
          multi_c = 1'b1;
        end else begin
          low_c = WAY_W'(i);
        end
        any_c = 1'b1;
      end
    end
    for (int unsigned l = 0; l < WAY_W; l++) begin
      victim_c[WAY_W-1-l] = tree_c[node];
      node = WAY_W'((32'(node) << 1) + 32'd1 + 32'(tree_c[node]));
    end
    way_c      = any_c ? low_c : victim_c;
    tree_upd_c = tree_c;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      b                 = way_c[WAY_W-1-l];
      tree_upd_c[unode] = ~b;
      unode = WAY_W'((32'(unode) << 1) + 32'd1 + 32'(b));
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    set_d      = set_q;
    hit_d      = hit_q;
    sel_d      = sel_q;
    resp_hit_d = resp_hit_q;
    err_d      = err_q;
    valid_d    = valid_q;
    plru_d     = plru_q;
    unique case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          state_d = ST_LOOKUP;
          set_d   = reqSet;
          hit_d   = hitVec;
        end
      end
      ST_LOOKUP: begin
        state_d        = ST_RESP;
        sel_d          = way_c;
        resp_hit_d     = any_c;
        err_d          = multi_c;
        valid_d        = 1'b1;
        plru_d[set_q]  = tree_upd_c;
      end
      ST_RESP: begin
        if (respReady) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State, capture, result and PLRU registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      set_q      <= '0;
      hit_q      <= '0;
      sel_q      <= '0;
      resp_hit_q <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      plru_q     <= '0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      hit_q      <= hit_d;
      sel_q      <= sel_d;
      resp_hit_q <= resp_hit_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      plru_q     <= plru_d;
    end
  end

  assign reqReady    = ready_q;
  assign select      = sel_q;
  assign respWay     = sel_q;
  assign respValid   = valid_q;
  assign respHit     = resp_hit_q;
  assign errMultiHit = err_q;

endmodule

// File: tb/tb_way_select_controller.sv
// Self-checking bench for way_select_controller with a range-halving PLRU model.
module tb_way_select_controller;

  localparam int WAYS = 8;
  localparam int SETS = 16;

  logic       clk;
  logic       rst_n;
  logic       reqValid;
  logic       reqReady;
  logic [3:0] reqSet;
  logic [7:0] hitVec;
  logic [2:0] select;
  logic       respValid;
  logic       respReady;
  logic       respHit;
  logic [2:0] respWay;
  logic       errMultiHit;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bit tree [SETS][WAYS-1];

  way_select_controller #(.lineSize(512), .ways(WAYS), .sets(SETS)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqReady(reqReady),
    .reqSet(reqSet), .hitVec(hitVec), .select(select), .respValid(respValid),
    .respReady(respReady), .respHit(respHit), .respWay(respWay),
    .errMultiHit(errMultiHit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int k = 0; k < WAYS - 1; k++) tree[s][k] = 1'b0;
  endfunction

  // Walk the tree by halving the candidate way range.
  function automatic int model_victim(input int s);
    int lo = 0;
    int hi = WAYS;
    int k  = 0;
    while (hi - lo > 1) begin
      int mid = (lo + hi) / 2;
      if (tree[s][k]) begin lo = mid; k = 2 * k + 2; end
      else begin hi = mid; k = 2 * k + 1; end
    end
    return lo;
  endfunction

  // Make every node on the way's path point to the other half.
  function automatic void model_touch(input int s, input int w);
    int lo = 0;
    int hi = WAYS;
    int k  = 0;
    while (hi - lo > 1) begin
      int mid = (lo + hi) / 2;
      if (w >= mid) begin tree[s][k] = 1'b0; lo = mid; k = 2 * k + 2; end
      else begin tree[s][k] = 1'b1; hi = mid; k = 2 * k + 1; end
    end
  endfunction

  function automatic void model_lookup(input int s, input logic [7:0] h,
                                       output int way, output bit hit, output bit err);
    int cnt = 0;
    way = 0;
    for (int i = 0; i < WAYS; i++) begin
      if (h[i]) begin
        if (cnt == 0) way = i;
        cnt++;
      end
    end
    hit = (cnt > 0);
    err = (cnt > 1);
    if (!hit) way = model_victim(s);
    model_touch(s, way);
  endfunction

  task automatic run_txn(input int s, input logic [7:0] h, input int stall, output int sel);
    int  ew;
    bit  eh;
    bit  ee;
    int  guard = 0;
    while (!reqReady && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", 32'(reqReady), 1);
    reqValid  = 1'b1;
    reqSet    = 4'(s);
    hitVec    = h;
    respReady = 1'b0;
    @(posedge clk); #1;
    reqValid = 1'b0;
    chk("lookup_ready_low", 32'(reqReady), 0);
    chk("lookup_no_valid", 32'(respValid), 0);
    model_lookup(s, h, ew, eh, ee);
    @(posedge clk); #1;
    chk("resp_valid", 32'(respValid), 1);
    chk("resp_select", 32'(select), 32'(ew));
    chk("resp_way", 32'(respWay), 32'(ew));
    chk("resp_hit", 32'(respHit), 32'(eh));
    chk("resp_err", 32'(errMultiHit), 32'(ee));
    chk("resp_ready_low", 32'(reqReady), 0);
    sel = int'(select);
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(respValid), 1);
      chk("stall_select", 32'(select), 32'(ew));
    end
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    chk("done_valid_low", 32'(respValid), 0);
    chk("done_ready", 32'(reqReady), 1);
    chk("idle_select_hold", 32'(select), 32'(ew));
  endtask

  initial begin
    int sel;
    int ew;
    bit eh;
    bit ee;
    rst_n     = 1'b0;
    reqValid  = 1'b0;
    reqSet    = '0;
    hitVec    = '0;
    respReady = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(reqReady), 1);
    chk("rst_valid", 32'(respValid), 0);
    chk("rst_select", 32'(select), 0);
    chk("rst_way", 32'(respWay), 0);
    chk("rst_hit", 32'(respHit), 0);
    chk("rst_err", 32'(errMultiHit), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Successive misses on one set walk the PLRU tree.
    run_txn(3, 8'h00, 0, sel); chk("miss3_a", 32'(sel), 0);
    run_txn(3, 8'h00, 0, sel); chk("miss3_b", 32'(sel), 4);
    run_txn(3, 8'h00, 0, sel); chk("miss3_c", 32'(sel), 2);

    // Hit updates PLRU; sets are independent.
    run_txn(5, 8'h20, 0, sel); chk("hit5", 32'(sel), 5);
    run_txn(5, 8'h00, 0, sel); chk("miss5", 32'(sel), 0);
    run_txn(6, 8'h00, 0, sel); chk("miss6", 32'(sel), 0);

    // Multi-hit picks the lowest way and flags the error.
    run_txn(1, 8'h48, 0, sel); chk("multi", 32'(sel), 3);

    // Stall in RESP with a request pending: nothing moves, nothing accepted.
    @(negedge clk);
    reqValid = 1'b1; reqSet = 4'd4; hitVec = 8'h01; respReady = 1'b0;
    model_lookup(4, 8'h01, ew, eh, ee);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stall_enter_valid", 32'(respValid), 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(respValid), 1);
      chk("hold_select", 32'(select), 32'(ew));
      chk("hold_way", 32'(respWay), 32'(ew));
      chk("hold_ready", 32'(reqReady), 0);
    end
    reqValid = 1'b0; respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    chk("hold_release", 32'(respValid), 0);

    // Reset during RESP abandons the transaction and clears PLRU state.
    @(negedge clk);
    reqValid = 1'b1; reqSet = 4'd3; hitVec = 8'h00;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(respValid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(respValid), 0);
    chk("midrst_select", 32'(select), 0);
    chk("midrst_ready", 32'(reqReady), 1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(3, 8'h00, 0, sel); chk("post_rst_miss3", 32'(sel), 0);

    // Back-to-back requests with respReady tied high: one response every 3 cycles.
    @(negedge clk);
    reqValid = 1'b1; reqSet = 4'd2; hitVec = 8'h00; respReady = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      chk("b2b_valid", 32'(respValid), (k % 3 == 1) ? 32'd1 : 32'd0);
      if (k % 3 == 1) begin
        model_lookup(2, 8'h00, ew, eh, ee);
        chk("b2b_select", 32'(select), 32'(ew));
      end
    end
    reqValid = 1'b0; respReady = 1'b0;

    // Randomized traffic against the reference model.
    for (int t = 0; t < 120; t++) begin
      int          s;
      int          kind;
      logic [7:0]  h;
      s    = int'($urandom_range(0, SETS - 1));
      kind = int'($urandom_range(0, 2));
      if (kind == 0) h = 8'h00;
      else if (kind == 1) h = 8'(1 << $urandom_range(0, WAYS - 1));
      else begin
        h = 8'(($urandom_range(1, 255)) | (1 << $urandom_range(0, 3)) | (1 << $urandom_range(4, 7)));
      end
      run_txn(s, h, int'($urandom_range(0, 2)), sel);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
